mem_stage_controller: RTL and testbench

- Sequences the MEM stage of the 5-stage pipeline around the data cache.
- Produces the `hit` advance-enable consumed by the MEM/WB pipeline register and the upstream stage registers.
- On a read miss, fetches the whole cache block from main memory, one word per handshake beat, and writes it into the cache.
- On any store, performs a write-through to main memory, stalling until the store is acknowledged.

---
 rtl/mem_stage_controller_pkg.sv | 24 ++
 rtl/mem_stage_controller_if.sv | 25 ++
 rtl/mem_stage_controller_sat_counter.sv | 20 ++
 rtl/mem_stage_controller.sv | 149 ++++++++++++++
 tb/tb_mem_stage_controller.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_controller_pkg.sv
// Shared types and constants for the MEM-stage cache controller.
// Includes the state encoding, the default block geometry and a helper for block offset bits.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } memState_e;

  localparam int unsigned DEFAULT_WORDS_PER_BLOCK = 4;
  localparam int unsigned DEFAULT_ADDR_WIDTH      = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH      = 32;
  localparam int unsigned DEFAULT_COUNT_WIDTH     = 16;
  localparam int unsigned DEFAULT_IDX_WIDTH       = $clog2(DEFAULT_WORDS_PER_BLOCK);
  localparam int unsigned DEFAULT_OFF             = DEFAULT_IDX_WIDTH + 2;

  // Byte-offset bits covered by one cache block of wordsPerBlock 32-bit words.
  function automatic int unsigned blockOffsetBits(input int unsigned wordsPerBlock);
    return $clog2(wordsPerBlock) + 2;
  endfunction

endpackage

// File: rtl/mem_stage_controller_if.sv
// Main-memory handshake bus between the MEM-stage controller and the memory.
// The controller drives the request side; the memory returns ready and read data.
interface mem_stage_controller_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  memReq;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic                  memReady;
  logic [DATA_WIDTH-1:0] memReadData;

  modport master (
    output memReq, memWe, memAddr, memWriteData,
    input  memReady, memReadData
  );

  modport slave (
    input  memReq, memWe, memAddr, memWriteData,
    output memReady, memReadData
  );

endinterface

// File: rtl/mem_stage_controller_sat_counter.sv
// Saturating event counter: increments on incEnable and sticks at all-ones.
// Used for the read-miss and write-through counters.
module sat_counter #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   incEnable,
  output logic [COUNT_WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (incEnable && (count != '1)) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_stage_controller.sv
// MEM-stage sequencer around the data cache: produces the pipeline advance enable,
// performs line fills on read misses and write-through on every store.
module mem_stage_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
  parameter int unsigned ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned COUNT_WIDTH     = DEFAULT_COUNT_WIDTH,
  localparam int unsigned IDX_WIDTH      = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   memRead,
  input  logic                   memWrite,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [DATA_WIDTH-1:0]  writeData,
  input  logic                   tagHit,
  mem_stage_controller_if.master memBus,
  output logic                   fillEnable,
  output logic [IDX_WIDTH-1:0]   fillWordIndex,
  output logic [DATA_WIDTH-1:0]  fillData,
  output logic                   hit,
  output logic [COUNT_WIDTH-1:0] missCount,
  output logic [COUNT_WIDTH-1:0] writeCount
);

  localparam int unsigned OFF = blockOffsetBits(WORDS_PER_BLOCK);

  memState_e             state;
  memState_e             stateNext;
  logic [IDX_WIDTH-1:0]  wordIdx;
  logic [IDX_WIDTH-1:0]  wordIdxNext;
  logic [ADDR_WIDTH-1:0] addrHold;
  logic [DATA_WIDTH-1:0] dataHold;
  logic [ADDR_WIDTH-1:0] fillAddr;
  logic [ADDR_WIDTH-1:0] writeAddr;
  logic                  missDone;
  logic                  writeDone;

  // Fill address is block base with the word index dropped into the offset field.
  assign fillAddr      = {address[ADDR_WIDTH-1:OFF], wordIdx, 2'b00};
  assign writeAddr     = address & ~ADDR_WIDTH'(3);
  assign fillWordIndex = wordIdx;
  assign fillData      = memBus.memReadData;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wordIdx <= '0;
    end else begin
      state   <= stateNext;
      wordIdx <= wordIdxNext;
    end
  end

  // Memory address/data keep their last driven value once the bus goes quiet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addrHold <= '0;
      dataHold <= '0;
    end else if (state == FILL) begin
      addrHold <= fillAddr;
    end else if (state == WRITE) begin
      addrHold <= writeAddr;
      dataHold <= writeData;
    end
  end

  always_comb begin
    stateNext           = state;
    wordIdxNext         = wordIdx;
    hit                 = 1'b0;
    fillEnable          = 1'b0;
    missDone            = 1'b0;
    writeDone           = 1'b0;
    memBus.memReq       = 1'b0;
    memBus.memWe        = 1'b0;
    memBus.memAddr      = addrHold;
    memBus.memWriteData = dataHold;

    case (state)
      IDLE: begin
        hit = !(memWrite || (memRead && !tagHit));
        if (memWrite) begin
          stateNext = WRITE;
        end else if (memRead && !tagHit) begin
          stateNext   = FILL;
          wordIdxNext = '0;
        end
      end
      FILL: begin
        memBus.memReq  = 1'b1;
        memBus.memAddr = fillAddr;
        fillEnable     = memBus.memReady;
        if (memBus.memReady) begin
          if (wordIdx == IDX_WIDTH'(WORDS_PER_BLOCK - 1)) begin
            stateNext   = DONE;
            wordIdxNext = '0;
            missDone    = 1'b1;
          end else begin
            wordIdxNext = wordIdx + IDX_WIDTH'(1);
          end
        end
      end
      WRITE: begin
        memBus.memReq       = 1'b1;
        memBus.memWe        = 1'b1;
        memBus.memAddr      = writeAddr;
        memBus.memWriteData = writeData;
        if (memBus.memReady) begin
          stateNext = DONE;
          writeDone = 1'b1;
        end
      end
      DONE: begin
        // Pipeline inputs still show the stalled instruction here; ignore them.
        hit       = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // Held reset lets upstream registers capture a bubble and kills any bus request.
    if (reset) begin
      hit           = 1'b1;
      fillEnable    = 1'b0;
      missDone      = 1'b0;
      writeDone     = 1'b0;
      memBus.memReq = 1'b0;
      memBus.memWe  = 1'b0;
    end
  end

  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) uMissCounter (
    .clock     (clock),
    .reset     (reset),
    .incEnable (missDone),
    .count     (missCount)
  );

  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) uWriteCounter (
    .clock     (clock),
    .reset     (reset),
    .incEnable (writeDone),
    .count     (writeCount)
  );

endmodule

// File: tb/tb_mem_stage_controller.sv
// Self-checking bench for mem_stage_controller: directed and randomized loads/stores
// compared against a transaction-level model of fills, write-throughs and counters.
module tb_mem_stage_controller;

  localparam int unsigned WPB      = 4;
  localparam int unsigned MISS_MAX = 65535;
  localparam int unsigned S_MAX    = 7;

  logic        clock;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        tagHit;
  logic        fillEnable;
  logic [1:0]  fillWordIndex;
  logic [31:0] fillData;
  logic        hit;
  logic [15:0] missCount;
  logic [15:0] writeCount;

  logic        sRead;
  logic        sWrite;
  logic [31:0] sAddr;
  logic [31:0] sWData;
  logic        sTagHit;
  logic        sFillEnable;
  logic [0:0]  sFillWordIndex;
  logic [31:0] sFillData;
  logic        sHit;
  logic [2:0]  sMissCount;
  logic [2:0]  sWriteCount;

  int tests;
  int fails;
  int expMiss;
  int expWrite;

  mem_stage_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus  ();
  mem_stage_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sBus ();

  mem_stage_controller #(
    .WORDS_PER_BLOCK(WPB), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COUNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .address(address), .writeData(writeData), .tagHit(tagHit), .memBus(bus),
    .fillEnable(fillEnable), .fillWordIndex(fillWordIndex), .fillData(fillData),
    .hit(hit), .missCount(missCount), .writeCount(writeCount)
  );

  // Small geometry/counter instance so saturation is reachable in a short run.
  mem_stage_controller #(
    .WORDS_PER_BLOCK(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COUNT_WIDTH(3)
  ) sDut (
    .clock(clock), .reset(reset), .memRead(sRead), .memWrite(sWrite),
    .address(sAddr), .writeData(sWData), .tagHit(sTagHit), .memBus(sBus),
    .fillEnable(sFillEnable), .fillWordIndex(sFillWordIndex), .fillData(sFillData),
    .hit(sHit), .missCount(sMissCount), .writeCount(sWriteCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int satInc(input int v, input int unsigned maxVal);
    return (v >= int'(maxVal)) ? int'(maxVal) : v + 1;
  endfunction

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic runMiss(input string name, input logic [31:0] addr, input int mode);
    logic [31:0] base;
    logic [31:0] rd;
    logic        rdy;
    int          beats;
    int          cyc;
    base = addr & ~32'(WPB * 4 - 1);
    memRead = 1'b1; memWrite = 1'b0; tagHit = 1'b0; address = addr; bus.memReady = 1'b0;
    #2;
    tests++;
    if (hit !== 1'b0 || bus.memReq !== 1'b0) begin
      fails++;
      $display("FAIL %s detect: hit=%0b memReq=%0b, expected hit=0 memReq=0", name, hit, bus.memReq);
    end
    nextCycle();
    beats = 0;
    cyc   = 0;
    while (beats < int'(WPB) && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 3) == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rd = $urandom;
      bus.memReady = rdy; bus.memReadData = rd;
      #2;
      tests++;
      if (hit !== 1'b0 || bus.memReq !== 1'b1 || bus.memWe !== 1'b0 ||
          bus.memAddr !== base + 32'(beats * 4) || fillEnable !== rdy ||
          fillWordIndex !== 2'(beats) || fillData !== rd) begin
        fails++;
        $display("FAIL %s beat%0d: hit=%0b req=%0b we=%0b addr=%h fillEn=%0b idx=%0d data=%h, expected hit=0 req=1 we=0 addr=%h fillEn=%0b idx=%0d data=%h",
                 name, beats, hit, bus.memReq, bus.memWe, bus.memAddr, fillEnable, fillWordIndex,
                 fillData, base + 32'(beats * 4), rdy, beats, rd);
      end
      if (rdy) beats++;
      cyc++;
      nextCycle();
    end
    bus.memReady = 1'b0;
    expMiss = satInc(expMiss, MISS_MAX);
    #2;
    tests++;
    if (cyc >= 200 || hit !== 1'b1 || bus.memReq !== 1'b0 || fillEnable !== 1'b0 ||
        bus.memAddr !== base + 32'((WPB - 1) * 4) || missCount !== 16'(expMiss)) begin
      fails++;
      $display("FAIL %s done: hit=%0b req=%0b fillEn=%0b addr=%h missCount=%0d cyc=%0d, expected hit=1 req=0 fillEn=0 addr=%h missCount=%0d",
               name, hit, bus.memReq, fillEnable, bus.memAddr, missCount, cyc,
               base + 32'((WPB - 1) * 4), expMiss);
    end
    nextCycle();
    memRead = 1'b0;
  endtask

  task automatic runWrite(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input int waitCycles, input logic alsoRead);
    logic [31:0] wAddr;
    wAddr = {addr[31:2], 2'b00};
    memWrite = 1'b1; memRead = alsoRead; tagHit = 1'b0; address = addr; writeData = data;
    bus.memReady = 1'b0;
    #2;
    tests++;
    if (hit !== 1'b0 || bus.memReq !== 1'b0) begin
      fails++;
      $display("FAIL %s detect: hit=%0b memReq=%0b, expected hit=0 memReq=0", name, hit, bus.memReq);
    end
    nextCycle();
    for (int i = 0; i <= waitCycles; i++) begin
      bus.memReady = (i == waitCycles);
      #2;
      tests++;
      if (hit !== 1'b0 || bus.memReq !== 1'b1 || bus.memWe !== 1'b1 || bus.memAddr !== wAddr ||
          bus.memWriteData !== data || fillEnable !== 1'b0) begin
        fails++;
        $display("FAIL %s cycle%0d: hit=%0b req=%0b we=%0b addr=%h wdata=%h fillEn=%0b, expected hit=0 req=1 we=1 addr=%h wdata=%h fillEn=0",
                 name, i, hit, bus.memReq, bus.memWe, bus.memAddr, bus.memWriteData, fillEnable,
                 wAddr, data);
      end
      nextCycle();
    end
    bus.memReady = 1'b0;
    expWrite = satInc(expWrite, MISS_MAX);
    #2;
    tests++;
    if (hit !== 1'b1 || bus.memReq !== 1'b0 || bus.memWe !== 1'b0 || fillEnable !== 1'b0 ||
        bus.memAddr !== wAddr || bus.memWriteData !== data ||
        writeCount !== 16'(expWrite) || missCount !== 16'(expMiss)) begin
      fails++;
      $display("FAIL %s done: hit=%0b req=%0b we=%0b addr=%h wdata=%h writeCount=%0d missCount=%0d, expected hit=1 req=0 we=0 addr=%h wdata=%h writeCount=%0d missCount=%0d",
               name, hit, bus.memReq, bus.memWe, bus.memAddr, bus.memWriteData, writeCount,
               missCount, wAddr, data, expWrite, expMiss);
    end
    nextCycle();
    memWrite = 1'b0; memRead = 1'b0;
  endtask

  task automatic runIdle(input string name, input logic load, input logic stray);
    logic [31:0] addrBefore;
    addrBefore = bus.memAddr;
    memRead = load; memWrite = 1'b0; tagHit = 1'b1; address = $urandom;
    bus.memReady = stray; bus.memReadData = $urandom;
    #2;
    tests++;
    if (hit !== 1'b1 || bus.memReq !== 1'b0 || bus.memWe !== 1'b0 || fillEnable !== 1'b0 ||
        bus.memAddr !== addrBefore || missCount !== 16'(expMiss) || writeCount !== 16'(expWrite)) begin
      fails++;
      $display("FAIL %s: hit=%0b req=%0b we=%0b fillEn=%0b addr=%h miss=%0d write=%0d, expected hit=1 req=0 we=0 fillEn=0 addr=%h miss=%0d write=%0d",
               name, hit, bus.memReq, bus.memWe, fillEnable, bus.memAddr, missCount, writeCount,
               addrBefore, expMiss, expWrite);
    end
    nextCycle();
    memRead = 1'b0; bus.memReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; memRead = 1'b1; memWrite = 1'b1; tagHit = 1'b0;
    address = 32'h0; writeData = 32'h0; bus.memReady = 1'b1; bus.memReadData = 32'h0;
    sRead = 1'b0; sWrite = 1'b0; sAddr = 32'h0; sWData = 32'h0; sTagHit = 1'b0;
    sBus.memReady = 1'b0; sBus.memReadData = 32'h0;
    expMiss = 0; expWrite = 0;
    #3;
    tests++;
    if (hit !== 1'b1 || bus.memReq !== 1'b0 || bus.memWe !== 1'b0 || fillEnable !== 1'b0 ||
        missCount !== 16'd0 || writeCount !== 16'd0) begin
      fails++;
      $display("FAIL reset_values: hit=%0b req=%0b we=%0b fillEn=%0b miss=%0d write=%0d, expected 1 0 0 0 0 0",
               hit, bus.memReq, bus.memWe, fillEnable, missCount, writeCount);
    end
    nextCycle();
    nextCycle();
    reset = 1'b0; memRead = 1'b0; memWrite = 1'b0; bus.memReady = 1'b0;
    #2;
    tests++;
    if (hit !== 1'b1 || bus.memReq !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: hit=%0b memReq=%0b, expected hit=1 memReq=0", hit, bus.memReq);
    end
    nextCycle();
  endtask

  task automatic test_read_miss();
    runMiss("read_miss_1238", 32'h0000_1238, 0);
  endtask

  task automatic test_slow_fill();
    runMiss("slow_fill", $urandom, 1);
  endtask

  task automatic test_write();
    runWrite("store_0104", 32'h0000_0104, 32'hDEAD_BEEF, 2, 1'b0);
    runWrite("store_unaligned", 32'h0000_2007, $urandom, 0, 1'b0);
  endtask

  task automatic test_read_write_priority();
    runWrite("read_and_write", $urandom, $urandom, 1, 1'b1);
  endtask

  task automatic test_stray_ready();
    for (int i = 0; i < 3; i++) runIdle("stray_ready_idle", 1'b0, 1'b1);
    runIdle("hit_load_zero_stall", 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    runMiss("b2b_miss_a", $urandom, 0);
    runWrite("b2b_store", $urandom, $urandom, 0, 1'b0);
    runMiss("b2b_miss_b", $urandom, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0:       runIdle("rand_nonmem", 1'b0, 1'($urandom_range(0, 1)));
        1:       runIdle("rand_hit_load", 1'b1, 1'($urandom_range(0, 1)));
        2:       runMiss("rand_miss", $urandom, 2);
        default: runWrite("rand_store", $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
      endcase
    end
  endtask

  task automatic test_reset_mid_fill();
    memRead = 1'b1; tagHit = 1'b0; address = $urandom; bus.memReady = 1'b0;
    nextCycle();
    #2;
    tests++;
    if (bus.memReq !== 1'b1 || hit !== 1'b0) begin
      fails++;
      $display("FAIL mid_fill_pre: memReq=%0b hit=%0b, expected memReq=1 hit=0", bus.memReq, hit);
    end
    reset = 1'b1; bus.memReady = 1'b1;
    #1;
    expMiss = 0; expWrite = 0;
    tests++;
    if (bus.memReq !== 1'b0 || hit !== 1'b1 || fillEnable !== 1'b0 ||
        missCount !== 16'd0 || writeCount !== 16'd0) begin
      fails++;
      $display("FAIL mid_fill_reset: memReq=%0b hit=%0b fillEn=%0b miss=%0d write=%0d, expected 0 1 0 0 0",
               bus.memReq, hit, fillEnable, missCount, writeCount);
    end
    nextCycle();
    nextCycle();
    reset = 1'b0; bus.memReady = 1'b0; memRead = 1'b1; tagHit = 1'b1;
    #2;
    tests++;
    if (hit !== 1'b1 || bus.memReq !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_hit_load: hit=%0b memReq=%0b, expected hit=1 memReq=0", hit, bus.memReq);
    end
    nextCycle();
    memRead = 1'b0;
    #2;
    tests++;
    if (bus.memReq !== 1'b0 || hit !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_no_reissue: memReq=%0b hit=%0b, expected memReq=0 hit=1", bus.memReq, hit);
    end
    nextCycle();
    runMiss("post_reset_miss", $urandom, 0);
  endtask

  task automatic test_saturation();
    bit sawLow;
    int cyc;
    int expS;
    expS = 0;
    for (int n = 1; n <= 10; n++) begin
      sRead = 1'b1; sTagHit = 1'b0; sAddr = $urandom; sBus.memReady = 1'b1;
      sawLow = 1'b0;
      cyc = 0;
      #2;
      while (!(sawLow && sHit) && cyc < 20) begin
        if (!sHit) sawLow = 1'b1;
        nextCycle();
        #2;
        cyc++;
      end
      expS = satInc(expS, S_MAX);
      tests++;
      if (cyc >= 20 || sMissCount !== 3'(expS)) begin
        fails++;
        $display("FAIL saturation miss%0d: missCount=%0d cycles=%0d, expected missCount=%0d within 20 cycles",
                 n, sMissCount, cyc, expS);
      end
      nextCycle();
      sRead = 1'b0; sBus.memReady = 1'b0;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_read_miss();
    test_slow_fill();
    test_write();
    test_read_write_priority();
    test_stray_ready();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
